// File: rtl/calf_ni_pkg.sv
// Shared flit layout, counter width and helpers for the CALF network interface.
// Flit: [143] valid, [142:139] dest, [138:135] src, [134:127] seq, [126:0] payload.
package calf_ni_pkg;

    localparam int NODE_W    = 4;
    localparam int SEQ_W     = 8;
    localparam int PAYLOAD_W = 127;
    localparam int CONTROL_W = 1 + 2 * NODE_W + SEQ_W;
    localparam int FLIT_W    = CONTROL_W + PAYLOAD_W;

    localparam int VALID_BIT  = FLIT_W - 1;
    localparam int DEST_HI    = VALID_BIT - 1;
    localparam int DEST_LO    = DEST_HI - NODE_W + 1;
    localparam int SRC_HI     = DEST_LO - 1;
    localparam int SRC_LO     = SRC_HI - NODE_W + 1;
    localparam int SEQ_HI     = SRC_LO - 1;
    localparam int SEQ_LO     = SEQ_HI - SEQ_W + 1;
    localparam int PAYLOAD_HI = SEQ_LO - 1;

    localparam int CNT_W = 16;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    function automatic flit_t make_flit(
        input logic [NODE_W-1:0]    dest,
        input logic [NODE_W-1:0]    src,
        input logic [SEQ_W-1:0]     seq,
        input logic [PAYLOAD_W-1:0] data
    );
        flit_t f;
        f                    = '0;
        f[VALID_BIT]         = 1'b1;
        f[DEST_HI:DEST_LO]   = dest;
        f[SRC_HI:SRC_LO]     = src;
        f[SEQ_HI:SEQ_LO]     = seq;
        f[PAYLOAD_HI:0]      = data;
        return f;
    endfunction

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/calf_ni_fifo.sv
// Circular FIFO shared by the inject and eject paths; a push while full is
// accepted only when a pop frees the head slot in the same cycle.
module ni_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == OCC_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the cleared occupancy masks stale entries.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/calf_ni.sv
// Network interface between a core and router port 4: stamps and queues
// outgoing payloads, and buffers ejected flits that the router cannot stall.
module calf_ni
    import calf_ni_pkg::*;
#(
    parameter int NODE_ID = 0,
    parameter int DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 core_in_valid,
    input  logic [NODE_W-1:0]    core_in_dest,
    input  logic [PAYLOAD_W-1:0] core_in_data,
    output logic                 core_in_ready,
    output logic [FLIT_W-1:0]    inj_flit,
    input  logic                 inj_ready,
    input  logic                 inj_ack,
    input  logic [FLIT_W-1:0]    ej_flit,
    output logic                 core_out_valid,
    output logic [FLIT_W-1:0]    core_out_flit,
    input  logic                 core_out_ready,
    output logic [CNT_W-1:0]     inj_cnt,
    output logic [CNT_W-1:0]     ej_cnt,
    output logic [CNT_W-1:0]     drop_cnt
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [SEQ_W-1:0] seq;
    logic             inj_push, inj_pop, inj_full, inj_empty, inj_present;
    flit_t            inj_head;
    logic [OCC_W-1:0] inj_count;

    logic             ej_in_valid, ej_push, ej_pop, ej_drop, ej_full, ej_empty;
    flit_t            ej_head;
    logic [OCC_W-1:0] ej_count;

    // Inject path: ready is held low during reset, never bypassed by a pop.
    assign core_in_ready = rst && !inj_full;
    assign inj_push      = core_in_valid && core_in_ready;
    assign inj_present   = !inj_empty && inj_ready;
    assign inj_flit      = inj_present ? inj_head : '0;
    assign inj_pop       = inj_present && inj_ack;

    ni_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_inj_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inj_push),
        .pop   (inj_pop),
        .wdata (make_flit(core_in_dest, NODE_W'(NODE_ID), seq, core_in_data)),
        .rdata (inj_head),
        .full  (inj_full),
        .empty (inj_empty),
        .count (inj_count)
    );

    // Eject path: the router cannot be stalled, so overflow is dropped and counted.
    assign ej_in_valid    = ej_flit[VALID_BIT];
    assign core_out_valid = !ej_empty;
    assign core_out_flit  = ej_empty ? '0 : ej_head;
    assign ej_pop         = core_out_valid && core_out_ready;
    assign ej_push        = ej_in_valid && (!ej_full || ej_pop);
    assign ej_drop        = ej_in_valid && ej_full && !ej_pop;

    ni_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_ej_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ej_push),
        .pop   (ej_pop),
        .wdata (ej_flit),
        .rdata (ej_head),
        .full  (ej_full),
        .empty (ej_empty),
        .count (ej_count)
    );

    // Occupancy is kept for debug visibility; the control here uses full/empty.
    logic unused_occupancy;
    assign unused_occupancy = ^{inj_count, ej_count};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq      <= '0;
            inj_cnt  <= '0;
            ej_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (inj_push) seq      <= seq + 1'b1;
            if (inj_pop)  inj_cnt  <= sat_inc(inj_cnt);
            if (ej_push)  ej_cnt   <= sat_inc(ej_cnt);
            if (ej_drop)  drop_cnt <= sat_inc(drop_cnt);
        end
    end

endmodule

// File: tb/tb_calf_ni.sv
// Directed bench for calf_ni: table of per-cycle inject vectors plus
// hand-written eject overflow, seq wrap and mid-operation reset sequences.
module tb_calf_ni;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         core_in_valid;
    logic [3:0]   core_in_dest;
    logic [126:0] core_in_data;
    logic         core_in_ready;
    logic [143:0] inj_flit;
    logic         inj_ready;
    logic         inj_ack;
    logic [143:0] ej_flit;
    logic         core_out_valid;
    logic [143:0] core_out_flit;
    logic         core_out_ready;
    logic [15:0]  inj_cnt;
    logic [15:0]  ej_cnt;
    logic [15:0]  drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    calf_ni #(.NODE_ID(5), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .core_in_valid  (core_in_valid),
        .core_in_dest   (core_in_dest),
        .core_in_data   (core_in_data),
        .core_in_ready  (core_in_ready),
        .inj_flit       (inj_flit),
        .inj_ready      (inj_ready),
        .inj_ack        (inj_ack),
        .ej_flit        (ej_flit),
        .core_out_valid (core_out_valid),
        .core_out_flit  (core_out_flit),
        .core_out_ready (core_out_ready),
        .inj_cnt        (inj_cnt),
        .ej_cnt         (ej_cnt),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        civ;
        logic [3:0]  dest;
        logic [7:0]  data;
        logic        irdy;
        logic        iack;
        logic        e_cir;
        logic        e_injv;
        logic [3:0]  e_dest;
        logic [7:0]  e_seq;
        logic [7:0]  e_data;
        logic [15:0] e_icnt;
    } vec_t;

    vec_t vt [13];

    function automatic vec_t mkv(logic civ, logic [3:0] dest, logic [7:0] data,
                                 logic irdy, logic iack, logic e_cir, logic e_injv,
                                 logic [3:0] e_dest, logic [7:0] e_seq,
                                 logic [7:0] e_data, logic [15:0] e_icnt);
        vec_t v;
        v.civ = civ; v.dest = dest; v.data = data; v.irdy = irdy; v.iack = iack;
        v.e_cir = e_cir; v.e_injv = e_injv; v.e_dest = e_dest; v.e_seq = e_seq;
        v.e_data = e_data; v.e_icnt = e_icnt;
        return v;
    endfunction

    // Expected injected flit for source node 5.
    function automatic logic [143:0] mk(logic [3:0] dest, logic [7:0] seq, logic [126:0] data);
        return {1'b1, dest, 4'd5, seq, data};
    endfunction

    function automatic logic [143:0] ejf(int k);
        return {1'b1, 4'd5, 4'hA, 8'(k), 127'(k + 100)};
    endfunction

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [143:0] junk;

        rst = 1'b1;
        core_in_valid = 1'b0; core_in_dest = '0; core_in_data = '0;
        inj_ready = 1'b0; inj_ack = 1'b0; ej_flit = '0; core_out_ready = 1'b0;

        vt[0]  = mkv(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 0);
        vt[1]  = mkv(1, 3, 8'h55, 1, 0, 1, 0, 0, 0, 8'h00, 0);
        vt[2]  = mkv(0, 0, 8'h00, 1, 0, 1, 1, 3, 0, 8'h55, 0);
        vt[3]  = mkv(0, 0, 8'h00, 1, 1, 1, 1, 3, 0, 8'h55, 0);
        vt[4]  = mkv(0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h00, 1);
        vt[5]  = mkv(0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 8'h00, 1);
        vt[6]  = mkv(1, 7, 8'h10, 0, 1, 1, 0, 0, 0, 8'h00, 1);
        vt[7]  = mkv(1, 7, 8'h11, 0, 1, 1, 0, 0, 0, 8'h00, 1);
        vt[8]  = mkv(1, 7, 8'h12, 0, 0, 1, 0, 0, 0, 8'h00, 1);
        vt[9]  = mkv(1, 7, 8'h13, 0, 0, 1, 0, 0, 0, 8'h00, 1);
        vt[10] = mkv(1, 7, 8'h14, 0, 0, 0, 0, 0, 0, 8'h00, 1);
        vt[11] = mkv(1, 7, 8'h15, 1, 1, 0, 1, 7, 1, 8'h10, 1);
        vt[12] = mkv(0, 0, 8'h00, 1, 0, 1, 1, 7, 2, 8'h11, 2);

        // Asynchronous reset state
        #2 rst = 1'b0;
        #1;
        chk("reset core_in_ready", 144'(core_in_ready), 144'(0));
        chk("reset inj_flit", inj_flit, '0);
        chk("reset core_out_valid", 144'(core_out_valid), 144'(0));
        chk("reset counters", 144'({inj_cnt, ej_cnt, drop_cnt}), '0);
        step();
        rst = 1'b1;

        // Inject path vectors: first flit, ignored acks, fill to full, refused push
        for (int r = 0; r < 13; r++) begin
            core_in_valid = vt[r].civ;
            core_in_dest  = vt[r].dest;
            core_in_data  = 127'(vt[r].data);
            inj_ready     = vt[r].irdy;
            inj_ack       = vt[r].iack;
            #1;
            chk($sformatf("row%0d core_in_ready", r), 144'(core_in_ready), 144'(vt[r].e_cir));
            chk($sformatf("row%0d inj_flit", r), inj_flit,
                vt[r].e_injv ? mk(vt[r].e_dest, vt[r].e_seq, 127'(vt[r].e_data)) : '0);
            chk($sformatf("row%0d inj_cnt", r), 144'(inj_cnt), 144'(vt[r].e_icnt));
            step();
        end

        // Drain the rest; the refused 0x14/0x15 pushes must not appear
        core_in_valid = 1'b0; inj_ready = 1'b1; inj_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("drain%0d inj_flit", k), inj_flit, mk(4'd7, 8'(2 + k), 127'(8'h11 + k)));
            step();
        end
        inj_ack = 1'b0;
        #1;
        chk("drain empty inj_flit", inj_flit, '0);
        chk("drain inj_cnt", 144'(inj_cnt), 144'(5));

        // Eject overflow: 5 flits into a 4-deep FIFO with the core stalled
        chk("ej empty core_out_flit", core_out_flit, '0);
        core_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ej_flit = ejf(k);
            #1;
            chk($sformatf("ej%0d core_out_valid", k), 144'(core_out_valid), 144'(k > 0));
            if (k > 0) chk($sformatf("ej%0d core_out_flit", k), core_out_flit, ejf(0));
            step();
        end
        ej_flit = '0;
        #1;
        chk("overflow ej_cnt", 144'(ej_cnt), 144'(4));
        chk("overflow drop_cnt", 144'(drop_cnt), 144'(1));
        chk("overflow head", core_out_flit, ejf(0));

        // Full FIFO with simultaneous pop and arrival: accepted, not dropped
        ej_flit = ejf(5); core_out_ready = 1'b1;
        #1;
        chk("pop+push head", core_out_flit, ejf(0));
        step();
        ej_flit = '0; core_out_ready = 1'b0;
        #1;
        chk("pop+push ej_cnt", 144'(ej_cnt), 144'(5));
        chk("pop+push drop_cnt", 144'(drop_cnt), 144'(1));
        chk("pop+push new head", core_out_flit, ejf(1));

        // A flit with valid=0 but other bits set is ignored
        junk = ejf(7);
        junk[143] = 1'b0;
        ej_flit = junk;
        step();
        ej_flit = '0;
        #1;
        chk("invalid ej ej_cnt", 144'(ej_cnt), 144'(5));
        chk("invalid ej drop_cnt", 144'(drop_cnt), 144'(1));

        core_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("eject order %0d", k), core_out_flit, ejf(k < 3 ? k + 1 : 5));
            step();
        end
        core_out_ready = 1'b0;
        #1;
        chk("eject drained valid", 144'(core_out_valid), 144'(0));
        chk("eject drained flit", core_out_flit, '0);

        // Fresh reset, then 257 back-to-back injections to wrap seq
        rst = 1'b0;
        #1;
        chk("reset2 counters", 144'({inj_cnt, ej_cnt, drop_cnt}), '0);
        step();
        rst = 1'b1;
        inj_ready = 1'b1; inj_ack = 1'b1;
        for (int i = 0; i <= 256; i++) begin
            core_in_valid = 1'b1;
            core_in_dest  = 4'(i);
            core_in_data  = 127'(i);
            #1;
            if (i > 0) chk($sformatf("wrap flit %0d", i - 1), inj_flit, mk(4'(i - 1), 8'(i - 1), 127'(i - 1)));
            step();
        end
        core_in_valid = 1'b0;
        #1;
        chk("wrap flit 257 seq 0", inj_flit, mk(4'd0, 8'd0, 127'(256)));
        step();
        inj_ack = 1'b0;
        #1;
        chk("wrap inj_cnt", 144'(inj_cnt), 144'(257));

        // Mid-burst asynchronous reset with both FIFOs occupied
        inj_ready = 1'b0; core_in_valid = 1'b1; core_in_data = 127'h99;
        ej_flit = ejf(9);
        step();
        ej_flit = '0;
        step();
        inj_ready = 1'b1;
        #1;
        chk("pre-reset inj_flit", inj_flit, mk(4'd0, 8'd1, 127'h99));
        chk("pre-reset core_out_valid", 144'(core_out_valid), 144'(1));
        #1 rst = 1'b0;
        #1;
        chk("midrst core_in_ready", 144'(core_in_ready), 144'(0));
        chk("midrst inj_flit", inj_flit, '0);
        chk("midrst core_out_valid", 144'(core_out_valid), 144'(0));
        chk("midrst core_out_flit", core_out_flit, '0);
        chk("midrst counters", 144'({inj_cnt, ej_cnt, drop_cnt}), '0);
        step();
        core_in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("post-reset core_in_ready", 144'(core_in_ready), 144'(1));
        chk("post-reset inj_flit", inj_flit, '0);
        core_in_valid = 1'b1; core_in_dest = 4'd2; core_in_data = 127'h77;
        step();
        core_in_valid = 1'b0;
        #1;
        chk("post-reset seq restart", inj_flit, mk(4'd2, 8'd0, 127'h77));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/calf_ni.md
CALF_NI -- requirements
Module: calf_ni

Interface
REQ-001 SHALL have parameter NODE_ID, default 0, meaning the 4-bit source ID stamped into every injected flit.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the entries per FIFO (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset, asynchronous and active-low.
REQ-005 SHALL have port core_in_valid, input, 1, meaning the core offers a payload.
REQ-006 SHALL have port core_in_dest, input, 4, meaning the destination node ID.
REQ-007 SHALL have port core_in_data, input, 127, meaning the payload.
REQ-008 SHALL have port core_in_ready, output, 1, meaning the inject FIFO is not full.
REQ-009 SHALL have port inj_flit, output, 144, meaning the flit driven to router port4_ci.
REQ-010 SHALL have port inj_ready, input, 1, meaning the router port4_ready (injection slot free this cycle).
REQ-011 SHALL have port inj_ack, input, 1, meaning the router port4_ack (the presented flit was consumed).
REQ-012 SHALL have port ej_flit, input, 144, meaning the router port4_co (ejected flit).
REQ-013 SHALL have port core_out_valid, output, 1, meaning an ejected flit is available.
REQ-014 SHALL have port core_out_flit, output, 144, meaning the head ejected flit.
REQ-015 SHALL have port core_out_ready, input, 1, meaning the core accepts the head.
REQ-016 SHALL have port inj_cnt, output, 16, meaning the saturating count of acked injections.
REQ-017 SHALL have port ej_cnt, output, 16, meaning the saturating count of flits accepted into the eject FIFO.
REQ-018 SHALL have port drop_cnt, output, 16, meaning the saturating count of ejected flits dropped because the eject FIFO was full.

Function
REQ-019 SHALL use flit format: [143] valid, [142:139] dest, [138:135] src, [134:127] seq, [126:0] payload.
REQ-020 SHALL push {1, dest, NODE_ID, seq, data} into the inject FIFO when core_in_valid && core_in_ready, then increment the 8-bit seq, wrapping 255->0.
REQ-021 SHALL drive core_in_ready = !inject_full, with no same-cycle bypass; a pop and push in the same cycle while full SHALL still refuse the push.
REQ-022 SHALL drive inj_flit = the inject FIFO head when not empty and inj_ready=1, otherwise all-zero (valid=0); a push at cycle N becomes visible at N+1 earliest.
REQ-023 SHALL pop the inject head only in a cycle with inj_ack=1 and valid inj_flit; inj_ack while the FIFO is empty or inj_ready=0 SHALL be ignored.
REQ-024 SHALL push ej_flit into the eject FIFO when ej_flit[143]=1 and the eject FIFO is not full, or is full with a pop in the same cycle; it SHALL then increment ej_cnt.
REQ-025 SHALL discard a valid ej_flit that arrives while the eject FIFO is full with no pop, and SHALL increment drop_cnt, because the router cannot be back-pressured.
REQ-026 SHALL make an ejected flit registered at N visible on core_out at N+1, and SHALL pop it on core_out_valid && core_out_ready.
REQ-027 SHALL drive core_out_flit = 0 when the eject FIFO is empty.
REQ-028 SHALL saturate all counters at 16'hFFFF.
REQ-029 SHALL keep FIFO pointers log2(DEPTH) bits with a separate occupancy count 0..DEPTH.

Reset
REQ-030 SHALL on rst=0 immediately clear FIFOs, seq, and counters; core_in_ready=0 while in reset, core_out_valid=0, inj_flit=0.
REQ-031 SHALL discard in-flight contents on reset mid-operation; core_in_ready=1 on the first clk edge after release.

Structure
REQ-032 SHALL place the flit width (144), field bit positions, and node-ID width in the shared defines alongside control_w.
REQ-033 SHALL implement both queues with one sub-module, ni_fifo (parameterised width/depth, push/pop/full/empty/count), instantiated twice.

Verification
REQ-034 SHALL cover: reset, push dest=3 data=0x55, inj_ready=1 -> inj_flit=valid,dest 3,src NODE_ID,seq 0 at next cycle; inj_ack -> pop, inj_cnt=1.
REQ-035 SHALL cover: inj_ready=0 for 5 cycles with 6 pushes -> core_in_ready=0 after 4, inj_flit=0, no pop.
REQ-036 SHALL cover: 5 consecutive valid ej_flit with core_out_ready=0 -> ej_cnt=4, drop_cnt=1, core_out holds first flit.
REQ-037 SHALL cover: eject FIFO full, core_out_ready=1 and valid ej_flit in same cycle -> no drop, ej_cnt increments.
REQ-038 SHALL cover: 256 injections -> seq wraps to 0 on flit 257; rst=0 asserted mid-burst -> all outputs zero asynchronously.
